seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display; one registered BCD-to-segment decoder is shared by all digits.
- Holds a double-buffered digit word and presents one nibble at a time on dig_data to the decoder.
- Drives the active-low common lines dig_sel, inserting blanking gaps between digits to avoid ghosting.
- Sits between the clock/UART control logic, which loads new time values, and the display decoder and pins.

Parameters:
- NUM_DIG, 6, number of digits scanned (>=2).
- DWELL, 1000, clk cycles each digit is driven (>=1).
- BLANK, 16, clk cycles all digits are off before each digit is driven (>=2; covers the decoder's 1-cycle register latency).

Ports:
- clk  in  1  system clock; all logic on posedge.
- resett  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe: capture load_data.
- load_data  in  4*NUM_DIG  digit nibbles; [3:0] = digit 0 (least significant).
- load_ack  out  1  1-cycle pulse when a pending word is committed to the display.
- dig_data  out  4  nibble to the shared segment decoder.
- dig_sel  out  NUM_DIG  one-hot active-low digit enable; all ones = display dark.
- frame_start  out  1  1-cycle pulse at each frame wrap.

Behaviour:
- Reset (resett=0, async):
  - dig_sel = all ones; dig_data = 0; load_ack = 0; frame_start = 0.
  - state = BLANK; idx = 0; timer = 0; shadow = 0; pending = 0; pending_valid = 0.
- FSM has two states, BLANK and DRIVE. All outputs are registered.
- BLANK:
  - dig_sel = all ones.
  - Lasts exactly BLANK cycles, then moves to DRIVE.
- DRIVE:
  - dig_sel[idx] = 0, all other bits 1.
  - Lasts exactly DWELL cycles, then idx advances and the FSM moves to BLANK.
- idx advance: idx+1, wrapping from NUM_DIG-1 to 0.
- dig_data:
  - Updated on the cycle BLANK is entered, to the nibble of the new idx.
  - Stable through the following BLANK and DRIVE.
- Frame timing:
  - Period = NUM_DIG*(BLANK+DWELL) cycles.
  - The first BLANK after reset release starts at idx 0.
- Frame wrap (DRIVE of idx NUM_DIG-1 ends):
  - frame_start pulses on the BLANK entry cycle.
  - If pending_valid: shadow <= pending, pending_valid <= 0, load_ack pulses in the same cycle, and dig_data takes pending[3:0] directly (new value is visible from digit 0).
  - No frame_start pulse after reset.
- Load handshake:
  - load=1 writes pending <= load_data and sets pending_valid <= 1.
  - A later load before commit overwrites pending (last wins); only one load_ack is produced per commit.
- Load on the same cycle as a wrap commit:
  - The old pending is committed and acked.
  - The new load_data becomes pending with pending_valid = 1, committed at the next wrap.
- Load during the last DWELL cycle (cycle before wrap): committed at the immediately following wrap.
- Counters: the timer is sized clog2(max(DWELL,BLANK)); idx is sized clog2(NUM_DIG). No overflow beyond the terminal count.
- Reset asserted mid-frame: immediate dark display; pending is discarded.

Optional Feature:
- Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined (leading-zero suppression):
  - In DRIVE of idx k (k>=1), dig_sel stays all ones if shadow nibbles k..NUM_DIG-1 are all zero.
  - Digit 0 is always shown.
  - Timing and frame period are unchanged.
- Undefined: all digits are always driven.

Decomposition:
- Package seg_scan_pkg:
  - state enum {BLANK, DRIVE}.
  - DIG_OFF constant (all ones).
  - Width helper for idx and timer.
- Sub-module seg_scan_timer: loadable down-counter with terminal-count flag, shared by BLANK and DRIVE.

Test Plan (NUM_DIG=4, DWELL=8, BLANK=2; frame = 40 cycles):
- Reset release, no load -> dig_sel = 1111 for 2 cycles, then 1110 for 8, 1111 for 2, 1101 for 8, ...; frame_start first pulses at cycle 40; dig_data = 0 throughout.
- load=1, load_data=16'h4321 at cycle 5 -> load_ack and frame_start together at cycle 40; dig_data = 1, 2, 3, 4 during the following DRIVE slots of idx 0..3.
- Loads 16'h1111 at cycle 10 then 16'h2222 at cycle 20 -> single load_ack at cycle 40; displayed word = 2222.
- Load 16'h5555 on the wrap cycle while 16'h1234 is pending -> 1234 committed and acked at cycle 40; 5555 committed and acked at cycle 80.
- resett pulsed low during a DRIVE slot -> dig_sel = 1111 and load_ack = 0 immediately; restart from idx 0 with a 2-cycle BLANK.
- With SEG_SCAN_LZ_BLANK_EN and word 16'h0050 -> idx 3 slot dark, idx 2 slot dark, idx 1 shows 5, idx 0 shows 0.

Source files
------------

// File: rtl/seg_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_pkg
//  Description : Shared types and helpers for the 7-segment scan controller.
//                - scan_state_e : the two scan phases (blank gap, digit drive)
//                - DIG_OFF      : all-ones pattern, sliced to NUM_DIG bits by
//                                 users, meaning every common line is off
//                - cnt_width()  : counter width helper (never returns 0)
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_scan_pkg;

    typedef enum logic [0:0] {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_e;

    localparam int unsigned MAX_DIG = 32;
    localparam logic [MAX_DIG-1:0] DIG_OFF = '1;

    // Bits needed to hold the values 0 .. n-1; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : seg_scan_pkg
`default_nettype wire

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_if
//  Description : Bus between the time-keeping/UART side and the scan
//                controller, plus the display-side outputs.
//  Ports       : load        - 1-cycle strobe capturing load_data
//                load_data   - 4*NUM_DIG digit nibbles, [3:0] = digit 0
//                load_ack    - 1-cycle pulse when a word reaches the display
//                dig_data    - nibble for the shared segment decoder
//                dig_sel     - one-hot active-low digit commons
//                frame_start - 1-cycle pulse at each frame wrap
//  Modports    : master - the loading side; slave - the scan controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_if #(
    parameter int unsigned NUM_DIG = 6
);
    logic                   load;
    logic [4*NUM_DIG-1:0]   load_data;
    logic                   load_ack;
    logic [3:0]             dig_data;
    logic [NUM_DIG-1:0]     dig_sel;
    logic                   frame_start;

    modport master (
        output load, load_data,
        input  load_ack, dig_data, dig_sel, frame_start
    );

    modport slave (
        input  load, load_data,
        output load_ack, dig_data, dig_sel, frame_start
    );
endinterface : seg_scan_if
`default_nettype wire

// File: rtl/seg_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_timer
//  Description : Loadable down-counter with terminal-count flag. Holds at
//                zero (no wrap) until reloaded. A phase of N cycles is
//                produced by loading N-1 on the phase entry edge.
//  Ports       : clk, resett (async, active-low)
//                load / load_val - reload request and value
//                tc              - count is zero (last cycle of the phase)
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_timer #(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resett,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - C_ONE;
        end
    end

    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule : seg_scan_timer
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexed scan controller for an NUM_DIG-digit
//                7-segment display. Each digit gets BLANK dark cycles then
//                DWELL driven cycles. A pending word loaded at any time is
//                committed to the displayed (shadow) word at the frame wrap,
//                so a frame never shows a mix of two words.
//  Ports       : clk    - system clock (posedge)
//                resett - asynchronous active-low reset
//                bus    - seg_scan_if.slave (load handshake + display side)
//  Options     : SEG_SCAN_LZ_BLANK_EN - leading-zero suppression: digit k>=1
//                stays dark when nibbles k..NUM_DIG-1 of the shown word are
//                all zero; timing is unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIG = 6,
    parameter int unsigned DWELL   = 1000,
    parameter int unsigned BLANK   = 16
) (
    input  logic        clk,
    input  logic        resett,
    seg_scan_if.slave   bus
);

    localparam int unsigned IW = cnt_width(NUM_DIG);
    localparam int unsigned TW = cnt_width((DWELL > BLANK) ? DWELL : BLANK);

    localparam logic [IW-1:0]      C_IDX_LAST   = IW'(NUM_DIG - 1);
    localparam logic [IW-1:0]      C_IDX_ONE    = IW'(1);
    localparam logic [TW-1:0]      C_BLANK_LAST = TW'(BLANK - 1);
    localparam logic [TW-1:0]      C_DWELL_LAST = TW'(DWELL - 1);
    localparam logic [NUM_DIG-1:0] C_SEL_OFF    = DIG_OFF[NUM_DIG-1:0];

    scan_state_e            state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*NUM_DIG-1:0]   shadow_q, shadow_d;
    logic [4*NUM_DIG-1:0]   pending_q, pending_d;
    logic                   pending_valid_q, pending_valid_d;
    logic [3:0]             dig_data_q, dig_data_d;
    logic [NUM_DIG-1:0]     dig_sel_q, dig_sel_d;
    logic                   load_ack_q, load_ack_d;
    logic                   frame_start_q, frame_start_d;

    logic                   timer_load;
    logic [TW-1:0]          timer_val;
    logic                   tc;
    logic [IW-1:0]          idx_next;
    logic                   load_taken;
    logic                   show_digit;

    // The timer comes out of reset already holding the first blank's
    // length, so the first gap after release is a full BLANK cycles long.
    seg_scan_timer #(
        .WIDTH   (TW),
        .RST_VAL (C_BLANK_LAST)
    ) u_timer (
        .clk      (clk),
        .resett   (resett),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (tc)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    // upper_zero[k]: nibbles k..NUM_DIG-1 of the shown word are all zero.
    logic [NUM_DIG-1:0] upper_zero;
    logic               zero_acc;

    always_comb begin
        zero_acc   = 1'b1;
        upper_zero = '0;
        for (int k = NUM_DIG - 1; k >= 0; k--) begin
            zero_acc      = zero_acc & (shadow_q[4*k +: 4] == 4'h0);
            upper_zero[k] = zero_acc;
        end
        show_digit = (idx_q == '0) || !upper_zero[idx_q];
    end
`else
    assign show_digit = 1'b1;
`endif

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        shadow_d        = shadow_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        dig_data_d      = dig_data_q;
        dig_sel_d       = dig_sel_q;
        load_ack_d      = 1'b0;
        frame_start_d   = 1'b0;
        timer_load      = 1'b0;
        timer_val       = C_BLANK_LAST;
        load_taken      = 1'b0;
        idx_next        = (idx_q == C_IDX_LAST) ? '0 : (idx_q + C_IDX_ONE);

        if (tc) begin
            timer_load = 1'b1;
            if (state_q == S_BLANK) begin
                state_d   = S_DRIVE;
                timer_val = C_DWELL_LAST;
                dig_sel_d = C_SEL_OFF;
                if (show_digit) begin
                    dig_sel_d[idx_q] = 1'b0;
                end
            end else begin
                state_d   = S_BLANK;
                timer_val = C_BLANK_LAST;
                dig_sel_d = C_SEL_OFF;
                idx_d     = idx_next;
                if (idx_q == C_IDX_LAST) begin
                    frame_start_d = 1'b1;
                    if (pending_valid_q) begin
                        // Older pending word wins this wrap; a load arriving
                        // on the same edge waits for the next wrap.
                        shadow_d        = pending_q;
                        pending_valid_d = 1'b0;
                        load_ack_d      = 1'b1;
                    end else if (bus.load) begin
                        // Nothing pending: a load in the last DWELL cycle
                        // goes straight to the display at this wrap.
                        shadow_d   = bus.load_data;
                        load_ack_d = 1'b1;
                        load_taken = 1'b1;
                    end
                end
                // Uses shadow_d so a word committed at the wrap is already
                // visible on digit 0.
                dig_data_d = shadow_d[4*idx_next +: 4];
            end
        end

        if (bus.load && !load_taken) begin
            pending_d       = bus.load_data;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            state_q         <= S_BLANK;
            idx_q           <= '0;
            shadow_q        <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            dig_data_q      <= 4'h0;
            dig_sel_q       <= C_SEL_OFF;
            load_ack_q      <= 1'b0;
            frame_start_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            shadow_q        <= shadow_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            dig_data_q      <= dig_data_d;
            dig_sel_q       <= dig_sel_d;
            load_ack_q      <= load_ack_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign bus.dig_data    = dig_data_q;
    assign bus.dig_sel     = dig_sel_q;
    assign bus.load_ack    = load_ack_q;
    assign bus.frame_start = frame_start_q;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Self-checking bench for seg_scan_ctrl (NUM_DIG=4, DWELL=8,
//                BLANK=2, 40-cycle frame). Cycle n is the interval after the
//                n-th rising edge following reset release; inputs and
//                samples are taken on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned DWELL   = 8;
    localparam int unsigned BLANK   = 2;
    localparam int unsigned SLOT    = BLANK + DWELL;
    localparam int unsigned FRAME   = NUM_DIG * SLOT;

`ifdef SEG_SCAN_LZ_BLANK_EN
    localparam logic [3:0] PRE1 = 4'hF, PRE2 = 4'hF, PRE3 = 4'hF;
    localparam logic [3:0] LZ2  = 4'hF, LZ3  = 4'hF;
`else
    localparam logic [3:0] PRE1 = 4'hD, PRE2 = 4'hB, PRE3 = 4'h7;
    localparam logic [3:0] LZ2  = 4'hB, LZ3  = 4'h7;
`endif

    logic clk    = 1'b0;
    logic resett = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIG(NUM_DIG)) bus ();

    seg_scan_ctrl #(
        .NUM_DIG (NUM_DIG),
        .DWELL   (DWELL),
        .BLANK   (BLANK)
    ) dut (
        .clk    (clk),
        .resett (resett),
        .bus    (bus)
    );

    typedef struct {
        int unsigned cyc;
        logic        ld;
        logic [15:0] ld_data;
        logic [3:0]  sel;
        logic [3:0]  data;
        logic        ack;
        logic        fs;
    } vec_t;

    vec_t tbl[$];

    int          checks   = 0;
    int          failures = 0;
    int unsigned n        = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_pend   = '0;
    bit          m_pv     = 1'b0;
    bit          m_ack    = 1'b0;
    logic [3:0]  obs_sel, obs_data;
    logic        obs_ack, obs_fs;
    int          ack_count    = 0;
    int          last_ack_cyc = -1;

    // ---------------- reference model (spec arithmetic) ----------------
    function automatic logic [3:0] nib(input logic [15:0] w, input int unsigned k);
        logic [15:0] t;
        t = w >> (4 * k);
        return t[3:0];
    endfunction

    function automatic logic [3:0] exp_sel(input int unsigned cyc, input logic [15:0] w);
        int unsigned p, slot;
        logic [3:0]  s;
        logic [15:0] upper;
        p     = cyc % FRAME;
        slot  = p / SLOT;
        s     = 4'hF;
        upper = w >> (4 * slot);
        if ((p % SLOT) >= BLANK) s[slot] = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (slot > 0 && upper == 16'h0) s = 4'hF;
`else
        if (upper == 16'hFFFF && slot > 3) s = 4'hF;
`endif
        return s;
    endfunction

    task automatic model_step(input logic ld, input logic [15:0] d);
        bit taken;
        taken = 1'b0;
        m_ack = 1'b0;
        if ((n + 1) % FRAME == 0) begin
            if (m_pv) begin
                m_shadow = m_pend;
                m_pv     = 1'b0;
                m_ack    = 1'b1;
            end else if (ld) begin
                m_shadow = d;
                m_ack    = 1'b1;
                taken    = 1'b1;
            end
        end
        if (ld && !taken) begin
            m_pend = d;
            m_pv   = 1'b1;
        end
        n++;
    endtask

    task automatic model_clear();
        n = 0; m_shadow = '0; m_pend = '0; m_pv = 1'b0; m_ack = 1'b0;
        ack_count = 0; last_ack_cyc = -1;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Called at a falling edge: drives inputs for cycle n, samples and
    // checks cycle n against the model, then advances to the next falling edge.
    task automatic cycle(input logic ld, input logic [15:0] d);
        bus.load      = ld;
        bus.load_data = d;
        obs_sel  = bus.dig_sel;
        obs_data = bus.dig_data;
        obs_ack  = bus.load_ack;
        obs_fs   = bus.frame_start;
        if (obs_ack === 1'b1) begin
            ack_count++;
            last_ack_cyc = int'(n);
        end
        chk("model_sel",  32'(obs_sel),  32'(exp_sel(n, m_shadow)));
        chk("model_data", 32'(obs_data), 32'(nib(m_shadow, (n % FRAME) / SLOT)));
        chk("model_ack",  32'(obs_ack),  32'(m_ack));
        chk("model_fs",   32'(obs_fs),   32'((n > 0) && (n % FRAME == 0)));
        @(posedge clk);
        model_step(ld, d);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        resett        = 1'b0;
        bus.load      = 1'b0;
        bus.load_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_sel",  32'(bus.dig_sel),     32'h0000_000F);
        chk("rst_data", 32'(bus.dig_data),    32'h0);
        chk("rst_ack",  32'(bus.load_ack),    32'h0);
        chk("rst_fs",   32'(bus.frame_start), 32'h0);
        resett = 1'b1;
        model_clear();
    endtask

    task automatic add(input int unsigned c, input logic ld, input logic [15:0] d,
                       input logic [3:0] s, input logic [3:0] dd, input logic a, input logic f);
        vec_t v;
        v.cyc = c; v.ld = ld; v.ld_data = d; v.sel = s; v.data = dd; v.ack = a; v.fs = f;
        tbl.push_back(v);
    endtask

    initial begin
        logic        ld;
        logic [15:0] d;
        bit          has;
        int          ti;

        bus.load      = 1'b0;
        bus.load_data = '0;

        // ---- table: idle scan then load 4321 at cycle 5 ----
        add( 0, 0, 16'h0,    4'hF, 4'h0, 0, 0);
        add( 1, 0, 16'h0,    4'hF, 4'h0, 0, 0);
        add( 2, 0, 16'h0,    4'hE, 4'h0, 0, 0);
        add( 5, 1, 16'h4321, 4'hE, 4'h0, 0, 0);
        add( 9, 0, 16'h0,    4'hE, 4'h0, 0, 0);
        add(10, 0, 16'h0,    4'hF, 4'h0, 0, 0);
        add(12, 0, 16'h0,    PRE1, 4'h0, 0, 0);
        add(22, 0, 16'h0,    PRE2, 4'h0, 0, 0);
        add(32, 0, 16'h0,    PRE3, 4'h0, 0, 0);
        add(39, 0, 16'h0,    PRE3, 4'h0, 0, 0);
        add(40, 0, 16'h0,    4'hF, 4'h1, 1, 1);
        add(42, 0, 16'h0,    4'hE, 4'h1, 0, 0);
        add(50, 0, 16'h0,    4'hF, 4'h2, 0, 0);
        add(52, 0, 16'h0,    4'hD, 4'h2, 0, 0);
        add(62, 0, 16'h0,    4'hB, 4'h3, 0, 0);
        add(72, 0, 16'h0,    4'h7, 4'h4, 0, 0);
        add(79, 0, 16'h0,    4'h7, 4'h4, 0, 0);
        add(80, 0, 16'h0,    4'hF, 4'h1, 0, 1);

        @(negedge clk);
        apply_reset();
        ti = 0;
        for (int c = 0; c <= 80; c++) begin
            has = (ti < tbl.size()) && (tbl[ti].cyc == c);
            ld  = has ? tbl[ti].ld : 1'b0;
            d   = has ? tbl[ti].ld_data : 16'h0;
            cycle(ld, d);
            if (has) begin
                chk("tbl_sel",  32'(obs_sel),  32'(tbl[ti].sel));
                chk("tbl_data", 32'(obs_data), 32'(tbl[ti].data));
                chk("tbl_ack",  32'(obs_ack),  32'(tbl[ti].ack));
                chk("tbl_fs",   32'(obs_fs),   32'(tbl[ti].fs));
                ti++;
            end
        end
        chk("tbl_entries_used", 32'(ti), 32'(tbl.size()));

        // ---- last load wins, single ack ----
        apply_reset();
        for (int c = 0; c <= 41; c++) begin
            cycle(c == 10 || c == 20, (c == 10) ? 16'h1111 : 16'h2222);
        end
        chk("lastwin_ack_count", 32'(ack_count),    32'd1);
        chk("lastwin_ack_cycle", 32'(last_ack_cyc), 32'd40);
        chk("lastwin_data",      32'(obs_data),     32'h2);

        // ---- load on the wrap edge while another word is pending ----
        apply_reset();
        for (int c = 0; c <= 80; c++) begin
            cycle(c == 15 || c == 39, (c == 15) ? 16'h1234 : 16'h5555);
            if (c == 40) chk("wrap_first_data", 32'(obs_data), 32'h4);
        end
        chk("wrap_ack_count", 32'(ack_count),    32'd2);
        chk("wrap_ack_cycle", 32'(last_ack_cyc), 32'd80);
        chk("wrap_second_data", 32'(obs_data),   32'h5);

        // ---- load in the last DWELL cycle with nothing pending ----
        apply_reset();
        for (int c = 0; c <= 40; c++) cycle(c == 39, 16'h9876);
        chk("late_ack",  32'(obs_ack),  32'h1);
        chk("late_data", 32'(obs_data), 32'h6);

        // ---- reset mid-DRIVE discards pending ----
        apply_reset();
        for (int c = 0; c < 25; c++) cycle(c == 3, 16'hABCD);
        resett = 1'b0;
        #1;
        chk("midrst_sel",  32'(bus.dig_sel),  32'h0000_000F);
        chk("midrst_ack",  32'(bus.load_ack), 32'h0);
        chk("midrst_data", 32'(bus.dig_data), 32'h0);
        @(negedge clk);
        resett = 1'b1;
        model_clear();
        for (int c = 0; c <= 45; c++) begin
            cycle(1'b0, 16'h0);
            if (c == 1) chk("midrst_blank", 32'(obs_sel), 32'h0000_000F);
            if (c == 2) chk("midrst_idx0",  32'(obs_sel), 32'h0000_000E);
        end
        chk("midrst_no_ack", 32'(ack_count), 32'd0);

        // ---- leading-zero word 0050 ----
        apply_reset();
        for (int c = 0; c <= 80; c++) begin
            cycle(c == 5, 16'h0050);
            if (c == 42) begin
                chk("lz_d0_sel", 32'(obs_sel), 32'h0000_000E);
                chk("lz_d0_data", 32'(obs_data), 32'h0);
            end
            if (c == 52) begin
                chk("lz_d1_sel", 32'(obs_sel), 32'h0000_000D);
                chk("lz_d1_data", 32'(obs_data), 32'h5);
            end
            if (c == 62) chk("lz_d2_sel", 32'(obs_sel), 32'(LZ2));
            if (c == 72) chk("lz_d3_sel", 32'(obs_sel), 32'(LZ3));
        end

        // ---- randomized loads against the model ----
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            ld = ($urandom_range(0, 9) == 0) ||
                 ((c % FRAME == FRAME - 1) && ($urandom_range(0, 1) == 1));
            d  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = d & 16'h00FF;
            cycle(ld, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
